// File: rtl/mem_read_responder_pkg.sv
// Shared types and constants for the instruction/data read responder.
package mem_read_responder_pkg;
    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_e;
endpackage

// File: rtl/rd_port_slot.sv
// Per-initiator-port bookkeeping: done flag, returned word, RVALID pulse and stall term.
module rd_port_slot
    import mem_read_responder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rden_i,
    input  logic              capture_i,
    input  logic              advance_i,
    input  logic [WORD_W-1:0] ram_rdata_i,
    output logic              pend_o,
    output logic              rvalid_o,
    output logic [WORD_W-1:0] rdata_o
);
    logic              done_q, done_d;
    logic              rvalid_q, rvalid_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    // A capture can never coincide with a completion of the same port: the
    // FSM only serves a port whose done flag is clear.
    always_comb begin
        done_d   = done_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        if (capture_i) begin
            done_d  = 1'b1;
            rdata_d = ram_rdata_i;
        end else if (advance_i && done_q) begin
            done_d   = 1'b0;
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign pend_o   = rden_i & ~done_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
endmodule

// File: rtl/mem_read_responder.sv
// Serves the core's instruction and data read ports from one req/ack RAM port,
// stalling the core until every presented read has been fetched.
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  INST_RDEN,
    input  logic [31:0]           INST_RADDR,
    output logic                  INST_RVALID,
    output logic [31:0]           INST_RDATA,
    input  logic                  DATA_RDEN,
    input  logic [31:0]           DATA_RADDR,
    output logic                  DATA_RVALID,
    output logic [31:0]           DATA_RDATA,
    output logic                  MEM_WAIT,
    output logic                  RAM_REQ,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    input  logic                  RAM_ACK,
    input  logic [31:0]           RAM_RDATA
);
    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pend_i, pend_d;
    logic                  cap_i, cap_d;
    logic                  pick_i, pick_d;
    logic [ADDR_WIDTH-1:0] inst_word, data_word;
    logic                  unused_addr_bits;

    assign inst_word = INST_RADDR[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
    assign data_word = DATA_RADDR[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
    assign unused_addr_bits = ^{INST_RADDR[31:ADDR_WIDTH+BYTE_OFF_W], INST_RADDR[BYTE_OFF_W-1:0],
                                DATA_RADDR[31:ADDR_WIDTH+BYTE_OFF_W], DATA_RADDR[BYTE_OFF_W-1:0]};

    assign MEM_WAIT = pend_i | pend_d;
    assign pick_d   = pend_d & (DATA_FIRST | ~pend_i);
    assign pick_i   = pend_i & (~DATA_FIRST | ~pend_d);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cap_i   = 1'b0;
        cap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = SERVE_D;
                    req_d   = 1'b1;
                    addr_d  = data_word;
                end else if (pick_i) begin
                    state_d = SERVE_I;
                    req_d   = 1'b1;
                    addr_d  = inst_word;
                end
            end
            // On ACK hand straight over to the other port if it is waiting.
            SERVE_I: begin
                if (req_q && RAM_ACK) begin
                    cap_i = 1'b1;
                    if (pend_d) begin
                        state_d = SERVE_D;
                        addr_d  = data_word;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            SERVE_D: begin
                if (req_q && RAM_ACK) begin
                    cap_d = 1'b1;
                    if (pend_i) begin
                        state_d = SERVE_I;
                        addr_d  = inst_word;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign RAM_REQ  = req_q;
    assign RAM_ADDR = addr_q;

    rd_port_slot u_inst (
        .clk_i       (CLK),
        .rst_i       (RST),
        .rden_i      (INST_RDEN),
        .capture_i   (cap_i),
        .advance_i   (~MEM_WAIT),
        .ram_rdata_i (RAM_RDATA),
        .pend_o      (pend_i),
        .rvalid_o    (INST_RVALID),
        .rdata_o     (INST_RDATA)
    );

    rd_port_slot u_data (
        .clk_i       (CLK),
        .rst_i       (RST),
        .rden_i      (DATA_RDEN),
        .capture_i   (cap_d),
        .advance_i   (~MEM_WAIT),
        .ram_rdata_i (RAM_RDATA),
        .pend_o      (pend_d),
        .rvalid_o    (DATA_RVALID),
        .rdata_o     (DATA_RDATA)
    );
endmodule

// File: tb/tb_mem_read_responder.sv
// Bench: two responders (data-first and inst-first) share one initiator and
// each gets its own wait-state RAM model; results are checked transaction by transaction.
module tb_mem_read_responder;
    localparam int AW = 14;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INST_RDEN = 1'b0;
    logic        DATA_RDEN = 1'b0;
    logic [31:0] INST_RADDR = '0;
    logic [31:0] DATA_RADDR = '0;

    logic          ivld[2], dvld[2], mw[2], req[2];
    logic          ack[2] = '{1'b0, 1'b0};
    logic [31:0]   idat[2], ddat[2];
    logic [31:0]   rdat[2] = '{32'h0, 32'h0};
    logic [AW-1:0] raddr[2];

    int checks = 0;
    int errors = 0;
    int ram_wait = 0;
    bit stray_ack = 1'b0;
    int cnt[2] = '{0, 0};
    int held[2] = '{0, 0};
    int served[2][$];

    always #5 CLK = ~CLK;

    // Instance 0 lets data win a tie, instance 1 lets instruction win.
    mem_read_responder #(.ADDR_WIDTH(AW), .DATA_FIRST(1'b1)) u_df1 (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR), .INST_RVALID(ivld[0]), .INST_RDATA(idat[0]),
        .DATA_RDEN(DATA_RDEN), .DATA_RADDR(DATA_RADDR), .DATA_RVALID(dvld[0]), .DATA_RDATA(ddat[0]),
        .MEM_WAIT(mw[0]), .RAM_REQ(req[0]), .RAM_ADDR(raddr[0]), .RAM_ACK(ack[0]), .RAM_RDATA(rdat[0])
    );

    mem_read_responder #(.ADDR_WIDTH(AW), .DATA_FIRST(1'b0)) u_df0 (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR), .INST_RVALID(ivld[1]), .INST_RDATA(idat[1]),
        .DATA_RDEN(DATA_RDEN), .DATA_RADDR(DATA_RADDR), .DATA_RVALID(dvld[1]), .DATA_RDATA(ddat[1]),
        .MEM_WAIT(mw[1]), .RAM_REQ(req[1]), .RAM_ADDR(raddr[1]), .RAM_ACK(ack[1]), .RAM_RDATA(rdat[1])
    );

    function automatic logic [31:0] mem_word(int w);
        return (w == 0) ? 32'h0000_0013 : ((32'(w) * 32'h9E37_79B1) ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing RAM: ACK after ram_wait stall cycles, address must not move meanwhile.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST || !req[k]) begin
                cnt[k]  <= 0;
                ack[k]  <= stray_ack;
                rdat[k] <= 32'hDEAD_BEEF;
            end else begin
                if (cnt[k] == 0) held[k] <= int'(raddr[k]);
                else chk("ram_addr_stable", 32'(raddr[k]), 32'(held[k]));
                if (cnt[k] == ram_wait) begin
                    ack[k]  <= 1'b1;
                    rdat[k] <= mem_word(int'(raddr[k]));
                    served[k].push_back(int'(raddr[k]));
                    cnt[k]  <= 0;
                end else begin
                    ack[k] <= 1'b0;
                    cnt[k] <= cnt[k] + 1;
                end
            end
        end
    end

    task automatic step(bit rel, bit ie, logic [31:0] ia, bit de, logic [31:0] da, int w);
        int n, exp_high, hi, wi, wd;
        int ord[2][$];
        @(posedge CLK); #1;
        if (rel) RST = 1'b0;
        ram_wait = w;
        served[0].delete();
        served[1].delete();
        INST_RDEN = ie; INST_RADDR = ia;
        DATA_RDEN = de; DATA_RADDR = da;
        wi = int'((ia >> 2) % (1 << AW));
        wd = int'((da >> 2) % (1 << AW));
        n = int'(ie) + int'(de);
        exp_high = (n == 0) ? 0 : 1 + n * (1 + w);
        if (de) ord[0].push_back(wd);
        if (ie) ord[0].push_back(wi);
        if (ie) ord[1].push_back(wi);
        if (de) ord[1].push_back(wd);
        hi = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            chk("mem_wait_agree", 32'(mw[0]), 32'(mw[1]));
            if (!mw[0]) break;
            hi++;
            for (int k = 0; k < 2; k++) chk("no_rvalid_while_wait", {30'b0, ivld[k], dvld[k]}, 32'h0);
        end
        chk("wait_cycles", 32'(hi), 32'(exp_high));
        @(posedge CLK); #1;
        INST_RDEN = 1'b0;
        DATA_RDEN = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("inst_rvalid", 32'(ivld[k]), 32'(ie));
            chk("data_rvalid", 32'(dvld[k]), 32'(de));
            if (ie) chk("inst_rdata", idat[k], mem_word(wi));
            if (de) chk("data_rdata", ddat[k], mem_word(wd));
        end
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("rvalid_one_cycle", {30'b0, ivld[k], dvld[k]}, 32'h0);
            chk("served_count", 32'(served[k].size()), 32'(ord[k].size()));
            for (int i = 0; i < ord[k].size() && i < served[k].size(); i++)
                chk("served_addr", 32'(served[k][i]), 32'(ord[k][i]));
        end
    endtask

    initial begin
        INST_RDEN = 1'b1;
        INST_RADDR = 32'h0;
        #12;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req", 32'(req[k]), 32'h0);
            chk("rst_addr", 32'(raddr[k]), 32'h0);
            chk("rst_rvalid", {30'b0, ivld[k], dvld[k]}, 32'h0);
            chk("rst_idata", idat[k], 32'h0);
            chk("rst_ddata", ddat[k], 32'h0);
            chk("rst_mem_wait", 32'(mw[k]), 32'h1);
        end

        // Release straight into a zero-wait fetch of word 0.
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 0);

        // Sequential fetch with two RAM wait states.
        step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 2);
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 2);
        step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 2);

        // Simultaneous requests, both arbitration orders observed at once.
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 0);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1237, 0);

        // Address wrap to the top RAM word.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1);

        // Stray ACK while idle must not disturb anything.
        @(posedge CLK); #1;
        stray_ack = 1'b1;
        served[0].delete();
        served[1].delete();
        repeat (3) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                chk("stray_req", 32'(req[k]), 32'h0);
                chk("stray_rvalid", {30'b0, ivld[k], dvld[k]}, 32'h0);
                chk("stray_mem_wait", 32'(mw[k]), 32'h0);
            end
        end
        stray_ack = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a slow fetch.
        @(posedge CLK); #1;
        ram_wait = 6;
        INST_RDEN = 1'b1;
        INST_RADDR = 32'h40;
        repeat (3) @(posedge CLK);
        #2;
        for (int k = 0; k < 2; k++) chk("req_before_reset", 32'(req[k]), 32'h1);
        RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("req_async_drop", 32'(req[k]), 32'h0);
            chk("reset_no_rvalid", {30'b0, ivld[k], dvld[k]}, 32'h0);
            chk("reset_no_ack", 32'(served[k].size()), 32'h0);
        end
        @(negedge CLK);
        INST_RDEN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) chk("post_reset_rvalid", {30'b0, ivld[k], dvld[k]}, 32'h0);
        step(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            bit ie, de;
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            if (!ie && !de) ie = 1'b1;
            step(1'b0, ie, $urandom, de, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
